fix_field_extractor: RTL and testbench
======================================

# fix_field_extractor

Downstream stage of `fix_parser`. Consumes its byte stream and tag/value boundary strobes. For each FIX field, converts the ASCII decimal tag to a binary tag number and captures the value bytes into a packed buffer. Presents one completed field at a time on a valid/ready output register for the message-level logic.

## Interface

Parameters:
- `TAG_W`, 16: width of the binary tag number.
- `MAX_VAL`, 16: maximum number of value bytes stored per field.
- `LEN_W`, 8: width of the value-length counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  `data_i` and the strobes are meaningful this cycle.
- `data_i`  in  8  byte from `fix_parser` `data_o`.
- `tag_s_i`  in  1  `data_i` is the first tag byte.
- `tag_e_i`  in  1  `data_i` is the last tag byte.
- `value_s_i`  in  1  `data_i` is the first value byte.
- `value_e_i`  in  1  `data_i` is the last value byte.
- `out_ready_i`  in  1  consumer accepts the held field.
- `field_valid_o`  out  1  output register holds a field.
- `tag_o`  out  TAG_W  binary tag number.
- `val_len_o`  out  LEN_W  true value length in bytes; saturates at 2^LEN_W-1.
- `val_o`  out  8*MAX_VAL  value bytes. Byte k is at [8k+7:8k]; bytes at or beyond the stored length are 0.
- `err_tag_o`  out  1  tag contained a non-digit or overflowed TAG_W.
- `err_trunc_o`  out  1  value was longer than MAX_VAL; extra bytes were dropped.
- `err_seq_o`  out  1  field was not well-formed. Pulses for 1 cycle; not registered with a field.
- `overrun_o`  out  1  completed field was dropped because the output was full. Pulses for 1 cycle.

## Operation

- Cycles with `valid_i`=0 are ignored completely, including the strobes.
- Working state: tag accumulator, length counter, value buffer and error flags. All are cleared when a new tag starts (`tag_s_i`).
- FSM states: IDLE, TAG, WAIT_VAL, VALUE.
- IDLE:
  - `tag_s_i` → accumulate the byte. Go to WAIT_VAL if `tag_e_i` is also set, otherwise go to TAG.
  - Any other strobe → pulse `err_seq_o`, stay in IDLE.
- TAG:
  - Accumulate each byte.
  - `tag_e_i` → WAIT_VAL.
  - `tag_s_i` → pulse `err_seq_o` and restart the tag with this byte.
- WAIT_VAL:
  - `value_s_i` → store the byte and set length to 1. If `value_e_i` is also set, emit the field; otherwise go to VALUE.
  - `tag_s_i` → pulse `err_seq_o` and restart in TAG (or WAIT_VAL if `tag_e_i` is also set).
  - Non-strobed bytes are ignored.
- VALUE:
  - Store each byte and increment length.
  - `value_e_i` → emit the field, go to IDLE.
  - `tag_s_i` → pulse `err_seq_o`, discard the partial field, restart the tag.
- Tag arithmetic: tag = tag*10 + (byte − 0x30), computed at TAG_W+4 bits.
  - Byte outside 0x30–0x39: digit is treated as 0, `err_tag` is set.
  - Result > 2^TAG_W−1: tag saturates at all-ones, `err_tag` is set.
- Value bytes at index ≥ MAX_VAL are not stored; `err_trunc` is set. The length counter still increments, saturating.
- Emit loads the output register with tag, length, buffer, `err_tag` and `err_trunc`, and sets `field_valid_o`.
- The output register holds until `field_valid_o` and `out_ready_i` are both high; `field_valid_o` then clears the next cycle unless a new emit occurs that cycle.
- Emit while the register is full and not being accepted: the new field is dropped, `overrun_o` pulses, the held field is kept.
- Emit and accept in the same cycle: the new field is loaded; no overrun.

## Timing

- Reset (`rst`=0, async):
  - State is IDLE; all working registers are 0.
  - Every output is 0: `field_valid_o`, `tag_o`, `val_len_o`, `val_o`, all error flags and `overrun_o`.
- Reset mid-field discards the partial field and any held output.
- Field latency: `field_valid_o` is high the cycle after the edge that samples the `value_e_i` byte.
- `err_seq_o` and `overrun_o` are registered and high for exactly the cycle after the offending edge.
- One byte per cycle is accepted. The next field's tag may start the cycle after `value_e_i`; no bubble is required.

## Test plan

- Parser output for "35=8" (tag_s on '3', tag_e on '5', value_s and value_e both on '8'), `out_ready_i`=1 → 1-cycle `field_valid_o`, `tag_o`=35, `val_len_o`=1, `val_o[7:0]`=0x38, no errors.
- "49=PHLX" → `tag_o`=49, `val_len_o`=4, `val_o[31:0]`=0x584C4850, upper bytes 0.
- "52=20071123-05:30:00.000" with MAX_VAL=16 → `tag_o`=52, `val_len_o`=21, `err_trunc_o`=1, `val_o` holds the first 16 bytes.
- Tag "9A" → `err_tag_o`=1, `tag_o`=90. Tag "99999" with TAG_W=16 → `tag_o`=0xFFFF, `err_tag_o`=1.
- Backpressure: `out_ready_i`=0, send "8=F" then "9=1" → the first field stays held, `overrun_o` pulses once. Assert ready on the cycle the second field emits → that field loads with no overrun.
- Sequence errors and reset:
  - `tag_s_i` mid-value → `err_seq_o` pulse, no emit.
  - `valid_i`=0 cycles inserted inside a field → identical result to the same field sent without gaps.
  - `rst` low mid-value → all outputs 0 and state IDLE; the next field decodes correctly.

Source files
------------

// File: rtl/fix_field_extractor.sv
// fix_field_extractor: turns parser tag/value strobes into a binary tag plus packed value buffer
module fix_field_extractor #(
    parameter int TAG_W   = 16,
    parameter int MAX_VAL = 16,
    parameter int LEN_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [7:0]           data_i,
    input  logic                 tag_s_i,
    input  logic                 tag_e_i,
    input  logic                 value_s_i,
    input  logic                 value_e_i,
    input  logic                 out_ready_i,
    output logic                 field_valid_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic [LEN_W-1:0]     val_len_o,
    output logic [8*MAX_VAL-1:0] val_o,
    output logic                 err_tag_o,
    output logic                 err_trunc_o,
    output logic                 err_seq_o,
    output logic                 overrun_o
);
    typedef enum logic [1:0] {IDLE, TAG, WAIT_VAL, VALUE} state_t;
    state_t state, state_nxt;
    logic [TAG_W-1:0]     acc, acc_nxt;
    logic [LEN_W-1:0]     len, len_nxt;
    logic [8*MAX_VAL-1:0] vbuf, vbuf_nxt;
    logic                 e_tag, e_tag_nxt, e_trunc, e_trunc_nxt;
    logic                 start, accum, store, emit, seq, ovf, is_dig;
    logic [7:0]           d_off;
    logic [TAG_W+3:0]     sum;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next state; a tag start always wins and restarts the field
    always_comb begin
        state_nxt = state;
        if (start)                                  state_nxt = tag_e_i ? WAIT_VAL : TAG;
        else if (valid_i && state == TAG && tag_e_i) state_nxt = WAIT_VAL;
        else if (emit)                              state_nxt = IDLE;
        else if (store)                             state_nxt = VALUE;
    end

    // per-byte actions decoded from state and strobes
    always_comb begin
        start = valid_i && tag_s_i;
        seq   = start ? state != IDLE
                      : valid_i && state == IDLE && (tag_e_i || value_s_i || value_e_i);
        store = valid_i && !tag_s_i && (state == VALUE || (state == WAIT_VAL && value_s_i));
        emit  = store && value_e_i;
        accum = start || (valid_i && state == TAG);
    end

    // tag arithmetic at TAG_W+4 bits and value byte placement
    always_comb begin
        d_off       = data_i - 8'h30;
        is_dig      = d_off < 8'd10;
        sum         = {4'b0, (start ? {TAG_W{1'b0}} : acc)} * (TAG_W+4)'(10)
                    + (TAG_W+4)'(d_off[3:0] & {4{is_dig}});
        ovf         = |sum[TAG_W+3:TAG_W];
        acc_nxt     = ovf ? {TAG_W{1'b1}} : sum[TAG_W-1:0];
        e_tag_nxt   = (e_tag && !start) || !is_dig || ovf;
        len_nxt     = &len ? len : len + LEN_W'(1);
        e_trunc_nxt = e_trunc || int'(len) >= MAX_VAL;
        vbuf_nxt    = vbuf;
        if (int'(len) < MAX_VAL) vbuf_nxt[8*len +: 8] = data_i;
    end

    // working registers, cleared whenever a new tag begins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            e_tag   <= 1'b0;
            len     <= '0;
            vbuf    <= '0;
            e_trunc <= 1'b0;
        end else begin
            if (accum) begin
                acc   <= acc_nxt;
                e_tag <= e_tag_nxt;
            end
            if (start) begin
                len     <= '0;
                vbuf    <= '0;
                e_trunc <= 1'b0;
            end else if (store) begin
                len     <= len_nxt;
                vbuf    <= vbuf_nxt;
                e_trunc <= e_trunc_nxt;
            end
        end
    end

    // output holding register with drop-on-full and registered pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            field_valid_o <= 1'b0;
            tag_o         <= '0;
            val_len_o     <= '0;
            val_o         <= '0;
            err_tag_o     <= 1'b0;
            err_trunc_o   <= 1'b0;
            err_seq_o     <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            err_seq_o <= seq;
            overrun_o <= emit && field_valid_o && !out_ready_i;
            if (emit && (!field_valid_o || out_ready_i)) begin
                field_valid_o <= 1'b1;
                tag_o         <= acc;
                val_len_o     <= len_nxt;
                val_o         <= vbuf_nxt;
                err_tag_o     <= e_tag;
                err_trunc_o   <= e_trunc_nxt;
            end else if (out_ready_i) begin
                field_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fix_field_extractor.sv
// tb_fix_field_extractor: directed FIX fields with a queue-based scoreboard on the output handshake
module tb_fix_field_extractor;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid_i = 1'b0;
    logic [7:0]   data_i = 8'h00;
    logic         tag_s_i = 1'b0, tag_e_i = 1'b0, value_s_i = 1'b0, value_e_i = 1'b0;
    logic         out_ready_i = 1'b1;
    logic         field_valid_o;
    logic [15:0]  tag_o;
    logic [7:0]   val_len_o;
    logic [127:0] val_o;
    logic         err_tag_o, err_trunc_o, err_seq_o, overrun_o;

    typedef struct {
        logic [15:0]  tag;
        logic [7:0]   len;
        logic [127:0] val;
        logic         et;
        logic         etr;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_seq = 0;
    int   n_ovr = 0;

    fix_field_extractor #(.TAG_W(16), .MAX_VAL(16), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
        .tag_s_i(tag_s_i), .tag_e_i(tag_e_i), .value_s_i(value_s_i), .value_e_i(value_e_i),
        .out_ready_i(out_ready_i), .field_valid_o(field_valid_o), .tag_o(tag_o),
        .val_len_o(val_len_o), .val_o(val_o), .err_tag_o(err_tag_o),
        .err_trunc_o(err_trunc_o), .err_seq_o(err_seq_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input int tag, input int len, input string v, input bit et, input bit etr);
        exp_t e;
        e.tag = 16'(tag);
        e.len = 8'(len);
        e.val = '0;
        for (int i = 0; i < v.len() && i < 16; i++) e.val[8*i +: 8] = v[i];
        e.et  = et;
        e.etr = etr;
        q.push_back(e);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic ts, input logic te,
                       input logic vs, input logic ve);
        valid_i = v; data_i = d; tag_s_i = ts; tag_e_i = te; value_s_i = vs; value_e_i = ve;
        @(posedge clk); #1;
    endtask

    task automatic send(input string t, input string v, input bit gaps, input bit rdy_last);
        for (int i = 0; i < t.len(); i++) begin
            cyc(1'b1, t[i], i == 0, i == t.len() - 1, 1'b0, 1'b0);
            if (gaps) cyc(1'b0, 8'h3d, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        for (int i = 0; i < v.len(); i++) begin
            if (rdy_last && i == v.len() - 1) out_ready_i = 1'b1;
            cyc(1'b1, v[i], 1'b0, 1'b0, i == 0, i == v.len() - 1);
            if (gaps) cyc(1'b0, 8'h7c, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_valid"}, 128'(field_valid_o), 128'd0);
        check({pfx, "_tag"}, 128'(tag_o), 128'd0);
        check({pfx, "_len"}, 128'(val_len_o), 128'd0);
        check({pfx, "_val"}, val_o, 128'd0);
        check({pfx, "_err_tag"}, 128'(err_tag_o), 128'd0);
        check({pfx, "_err_trunc"}, 128'(err_trunc_o), 128'd0);
        check({pfx, "_err_seq"}, 128'(err_seq_o), 128'd0);
        check({pfx, "_overrun"}, 128'(overrun_o), 128'd0);
    endtask

    // monitor: counts pulses and scores every accepted field
    always @(negedge clk) begin
        if (rst) begin
            if (err_seq_o) n_seq++;
            if (overrun_o) n_ovr++;
            if (field_valid_o && out_ready_i) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_field: got tag %0d expected no field", tag_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("field_tag", 128'(tag_o), 128'(e.tag));
                    check("field_len", 128'(val_len_o), 128'(e.len));
                    check("field_val", val_o, e.val);
                    check("field_err_tag", 128'(err_tag_o), 128'(e.et));
                    check("field_err_trunc", 128'(err_trunc_o), 128'(e.etr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #23;
        check_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        push(35, 1, "8", 1'b0, 1'b0);
        send("35", "8", 1'b0, 1'b0);
        push(49, 4, "PHLX", 1'b0, 1'b0);
        send("49", "PHLX", 1'b0, 1'b0);
        push(52, 21, "20071123-05:30:0", 1'b0, 1'b1);
        send("52", "20071123-05:30:00.000", 1'b0, 1'b0);
        push(90, 1, "x", 1'b1, 1'b0);
        send("9A", "x", 1'b0, 1'b0);
        push(16'hFFFF, 1, "y", 1'b1, 1'b0);
        send("99999", "y", 1'b0, 1'b0);
        push(49, 4, "PHLX", 1'b0, 1'b0);
        send("49", "PHLX", 1'b1, 1'b0);
        idle(3);
        check("queue_drained_basic", 128'(q.size()), 128'd0);
        check("phlx_direct", val_o, 128'h584C4850);

        cyc(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h35, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h35, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 1'b0);
        push(10, 1, "z", 1'b0, 1'b0);
        send("10", "z", 1'b0, 1'b0);
        idle(3);
        check("err_seq_count", 128'(n_seq), 128'd2);
        check("queue_drained_seq", 128'(q.size()), 128'd0);

        out_ready_i = 1'b0;
        push(8, 1, "F", 1'b0, 1'b0);
        send("8", "F", 1'b0, 1'b0);
        send("9", "1", 1'b0, 1'b0);
        idle(2);
        check("held_valid", 128'(field_valid_o), 128'd1);
        check("held_tag", 128'(tag_o), 128'd8);
        check("overrun_count", 128'(n_ovr), 128'd1);
        push(7, 1, "2", 1'b0, 1'b0);
        send("7", "2", 1'b0, 1'b1);
        idle(3);
        check("overrun_after_accept", 128'(n_ovr), 128'd1);
        check("queue_drained_bp", 128'(q.size()), 128'd0);

        out_ready_i = 1'b0;
        send("8", "F", 1'b0, 1'b0);
        cyc(1'b1, 8'h35, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h38, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 1'b0);
        valid_i = 1'b1; data_i = 8'h62; value_s_i = 1'b0;
        rst = 1'b0;
        #2;
        check_zero("midreset");
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        push(35, 1, "8", 1'b0, 1'b0);
        send("35", "8", 1'b0, 1'b0);
        idle(3);
        check("queue_drained_final", 128'(q.size()), 128'd0);
        check("err_seq_final", 128'(n_seq), 128'd2);
        check("overrun_final", 128'(n_ovr), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
